// File: rtl/jt89_writer.sv
// jt89_writer: queues register-level PSG commands and serialises them into SN76489 latch/data bytes.
// Optional macro JT89_SKIP_EN adds register shadows that drop redundant volume and data writes.
module jt89_writer #(
    parameter int FIFO_AW = 2,
    parameter int WR_LOW  = 2,
    parameter int WR_HIGH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [2:0]         cmd_reg,
    input  logic [9:0]         cmd_data,
    input  logic               psg_ready,
    output logic               wr_n,
    output logic [7:0]         dout,
    output logic               busy,
    output logic [FIFO_AW:0]   level,
    output logic               skipped
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CMAX  = (WR_LOW > WR_HIGH) ? WR_LOW : WR_HIGH;
    localparam int CW    = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [FIFO_AW:0] FULL     = (FIFO_AW+1)'(DEPTH);
    localparam logic [CW-1:0]    LOW_END  = CW'(WR_LOW - 1);
    localparam logic [CW-1:0]    HIGH_END = CW'(WR_HIGH - 1);

    typedef enum logic [2:0] {IDLE, LOW1, HIGH1, LOW2, HIGH2} state_t;

    state_t state, nxt;

    logic [12:0]        mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic               push, pop;

    logic [2:0]    head_reg;
    logic [9:0]    head_data;
    logic          head_vol, head_noise, head_tone;
    logic [7:0]    latch_byte;
    logic          drop_vol, tone_same;

    logic [CW-1:0] cnt;
    logic          need_data;
    logic [5:0]    data_hi;
    logic          start, take;
    logic          ld_latch, ld_data, rise, cnt_clr, cnt_inc, skip_p;

    assign cmd_ready = (level != FULL);
    assign push      = cmd_valid && cmd_ready;
    assign busy      = (level != '0) || (state != IDLE);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {cmd_reg, cmd_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: ;
            endcase
        end
    end

    assign {head_reg, head_data} = mem[rd_ptr];
    assign head_vol   = head_reg[0];
    assign head_noise = (head_reg == 3'b110);
    assign head_tone  = !head_vol && !head_noise;
    assign latch_byte = {1'b1, head_reg, head_noise ? {1'b0, head_data[2:0]} : head_data[3:0]};

`ifdef JT89_SKIP_EN
    logic [9:0] shadow [8];

    assign drop_vol  = head_vol  && (shadow[head_reg][3:0] == head_data[3:0]);
    assign tone_same = head_tone && (shadow[head_reg][9:4] == head_data[9:4]);

    // Shadows mirror the chip's registers as of the last pop, dropped writes included.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++)
                shadow[i] <= (i % 2 == 1) ? 10'h00F : ((i == 6) ? 10'h004 : 10'h000);
        end else if (pop) begin
            shadow[head_reg] <= head_data;
        end
    end
`else
    assign drop_vol  = 1'b0;
    assign tone_same = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    // The final HIGH cycle of a sequence can launch the next command directly,
    // so back-to-back bytes are separated by exactly WR_HIGH high cycles.
    always_comb begin
        nxt      = state;
        pop      = 1'b0;
        ld_latch = 1'b0;
        ld_data  = 1'b0;
        rise     = 1'b0;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        skip_p   = 1'b0;
        take     = 1'b0;
        start    = (level != '0) && psg_ready;
        case (state)
            IDLE: take = 1'b1;
            LOW1, LOW2: begin
                if (cnt == LOW_END) begin
                    rise    = 1'b1;
                    cnt_clr = 1'b1;
                    nxt     = (state == LOW1) ? HIGH1 : HIGH2;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            HIGH1: begin
                if (cnt != HIGH_END) begin
                    cnt_inc = 1'b1;
                end else if (need_data) begin
                    if (psg_ready) begin
                        ld_data = 1'b1;
                        cnt_clr = 1'b1;
                        nxt     = LOW2;
                    end
                end else begin
                    take = 1'b1;
                end
            end
            HIGH2: begin
                if (cnt != HIGH_END) cnt_inc = 1'b1;
                else                 take    = 1'b1;
            end
            default: nxt = IDLE;
        endcase
        if (take) begin
            nxt = IDLE;
            if (start) begin
                pop = 1'b1;
                if (drop_vol) begin
                    skip_p = 1'b1;
                end else begin
                    ld_latch = 1'b1;
                    cnt_clr  = 1'b1;
                    nxt      = LOW1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_n      <= 1'b1;
            dout      <= 8'h00;
            cnt       <= '0;
            need_data <= 1'b0;
            data_hi   <= '0;
            skipped   <= 1'b0;
        end else begin
            skipped <= skip_p;
            if (cnt_clr)      cnt <= '0;
            else if (cnt_inc) cnt <= cnt + 1'b1;
            if (ld_latch) begin
                dout      <= latch_byte;
                wr_n      <= 1'b0;
                need_data <= head_tone && !tone_same;
                data_hi   <= head_data[9:4];
            end else if (ld_data) begin
                dout <= {2'b00, data_hi};
                wr_n <= 1'b0;
            end else if (rise) begin
                wr_n <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_jt89_writer.sv
// Bench for jt89_writer: table vectors, hand corner sequences and a randomized run
// against a byte-level reference model (model follows JT89_SKIP_EN when defined).
module tb_jt89_writer;
    localparam int FIFO_AW = 2;
    localparam int WR_LOW  = 2;
    localparam int WR_HIGH = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [2:0]       cmd_reg = 3'b000;
    logic [9:0]       cmd_data = 10'h000;
    logic             psg_ready = 1'b1;
    logic             wr_n;
    logic [7:0]       dout;
    logic             busy;
    logic [FIFO_AW:0] level;
    logic             skipped;

    jt89_writer #(.FIFO_AW(FIFO_AW), .WR_LOW(WR_LOW), .WR_HIGH(WR_HIGH)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_reg(cmd_reg), .cmd_data(cmd_data), .psg_ready(psg_ready),
        .wr_n(wr_n), .dout(dout), .busy(busy), .level(level), .skipped(skipped)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference model: expected byte stream plus register shadows, in command order.
    logic [7:0] exp_q[$];
    logic [7:0] obs[$];
    logic [9:0] msh[8];
    int         exp_skips = 0;
    int         skip_cnt = 0;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) msh[i] = (i % 2 == 1) ? 10'h00F : ((i == 6) ? 10'h004 : 10'h000);
        exp_q.delete();
    endtask

    task automatic model_cmd(input logic [2:0] r, input logic [9:0] d);
        bit drop = 0;
        bit nodata = 0;
`ifdef JT89_SKIP_EN
        drop   = r[0] && (msh[r][3:0] == d[3:0]);
        nodata = (msh[r][9:4] == d[9:4]);
`endif
        if (r == 3'b110) begin
            exp_q.push_back({1'b1, r, 1'b0, d[2:0]});
        end else if (r[0]) begin
            if (drop) exp_skips++;
            else      exp_q.push_back({1'b1, r, d[3:0]});
        end else begin
            exp_q.push_back({1'b1, r, d[3:0]});
            if (!nodata) exp_q.push_back({2'b00, d[9:4]});
        end
        msh[r] = d;
    endtask

    // Byte monitor: records each falling-edge byte, checks strobe widths and dout hold.
    int   lo_cnt = 0, hi_cnt = 0;
    bit   in_low = 0, seen_rise = 0, prev_wr = 1;
    logic [7:0] cap = 8'h00;
    always @(negedge clk) begin
        if (rst) begin
            in_low = 0; seen_rise = 0; prev_wr = 1;
        end else begin
            if (skipped) skip_cnt++;
            if (prev_wr && !wr_n) begin
                if (seen_rise) chk(hi_cnt >= WR_HIGH, "high_gap", hi_cnt, WR_HIGH);
                cap = dout; obs.push_back(dout); in_low = 1; lo_cnt = 1;
            end else if (!prev_wr && !wr_n) begin
                lo_cnt++;
                chk(dout == cap, "dout_stable", dout, cap);
            end else if (!prev_wr && wr_n) begin
                if (in_low) chk(lo_cnt == WR_LOW, "low_len", lo_cnt, WR_LOW);
                in_low = 0; seen_rise = 1; hi_cnt = 1;
            end else begin
                hi_cnt++;
            end
            prev_wr = wr_n;
        end
    end

    task automatic push(input logic [2:0] r, input logic [9:0] d);
        int t = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_reg = r; cmd_data = d;
        while (!cmd_ready && t < 200) begin @(negedge clk); t++; end
        if (!cmd_ready) begin
            chk(1'b0, "push_timeout", cmd_ready, 1);
            cmd_valid = 1'b0;
        end else begin
            model_cmd(r, d);
            @(posedge clk); #1;
            cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while (busy && t < 3000) begin @(negedge clk); t++; end
        chk(!busy, "idle_timeout", busy, 0);
    endtask

    task automatic check_bytes(input string nm);
        chk(obs.size() == exp_q.size(), {nm, "_count"}, obs.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++)
            chk(obs[i] == exp_q[i], nm, obs[i], exp_q[i]);
        obs.delete(); exp_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        obs.delete();
    endtask

    typedef struct { logic [2:0] r; logic [9:0] d; int n; logic [7:0] b0; logic [7:0] b1; } vec_t;
    vec_t tbl[6];
    bit   rnd_done = 0;

    initial begin
        tbl[0] = '{3'b010, 10'h3A5, 2, 8'hA5, 8'h3A};
        tbl[1] = '{3'b101, 10'h007, 1, 8'hD7, 8'h00};
        tbl[2] = '{3'b110, 10'h003, 1, 8'hE3, 8'h00};
        tbl[3] = '{3'b100, 10'h3FF, 2, 8'hCF, 8'h3F};
        tbl[4] = '{3'b001, 10'h000, 1, 8'h90, 8'h00};
        tbl[5] = '{3'b000, 10'h200, 2, 8'h80, 8'h20};

        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk(wr_n == 1'b1, "rst_wr_n", wr_n, 1);
        chk(dout == 8'h00, "rst_dout", dout, 0);
        chk(cmd_ready == 1'b1, "rst_cmd_ready", cmd_ready, 1);
        chk(busy == 1'b0, "rst_busy", busy, 0);
        chk(level == '0, "rst_level", level, 0);
        chk(skipped == 1'b0, "rst_skipped", skipped, 0);
        @(posedge clk); #1 rst = 1'b0;

        // Table vectors; the first one also checks accept-to-strobe latency.
        for (int i = 0; i < 6; i++) begin
            push(tbl[i].r, tbl[i].d);
            if (i == 0) begin
                @(negedge clk);
                chk(wr_n == 1'b1, "lat_before_pop", wr_n, 1);
                chk(level == 1, "lat_level1", level, 1);
                @(negedge clk);
                chk(wr_n == 1'b0, "lat_strobe", wr_n, 0);
                chk(level == 0, "lat_level0", level, 0);
            end
            wait_idle();
            chk(obs.size() == tbl[i].n, "tbl_count", obs.size(), tbl[i].n);
            if (obs.size() >= 1) chk(obs[0] == tbl[i].b0, "tbl_byte0", obs[0], tbl[i].b0);
            if (tbl[i].n == 2 && obs.size() >= 2) chk(obs[1] == tbl[i].b1, "tbl_byte1", obs[1], tbl[i].b1);
            obs.delete(); exp_q.delete();
        end

        // FIFO fill with the PSG stalled, then a fifth command accepted after the first pop.
        psg_ready = 1'b0;
        push(3'b001, 10'h001);
        push(3'b011, 10'h002);
        push(3'b101, 10'h003);
        push(3'b111, 10'h004);
        @(negedge clk);
        chk(level == 4, "full_level", level, 4);
        chk(cmd_ready == 1'b0, "full_ready", cmd_ready, 0);
        fork
            push(3'b000, 10'h2AB);
            begin repeat (3) @(negedge clk); psg_ready = 1'b1; end
        join
        wait_idle();
        check_bytes("fifo_order");

        // PSG stalls during HIGH1 of a tone command.
        push(3'b100, 10'h155);
        begin
            int t = 0;
            while (!(obs.size() >= 1 && wr_n) && t < 100) begin @(negedge clk); t++; end
        end
        psg_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk(wr_n == 1'b1 && dout == 8'hC5, "stall_hold", {wr_n, dout}, {1'b1, 8'hC5});
        end
        psg_ready = 1'b1;
        wait_idle();
        check_bytes("stall_tone");

        // Reset while the data byte strobe is low.
        push(3'b000, 10'h3C6);
        begin
            int t = 0;
            while (obs.size() < 2 && t < 100) begin @(negedge clk); t++; end
        end
        chk(wr_n == 1'b0, "low2_reached", wr_n, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk(wr_n == 1'b1, "abort_wr_n", wr_n, 1);
        chk(level == 0, "abort_level", level, 0);
        chk(busy == 1'b0, "abort_busy", busy, 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (20) @(negedge clk);
        check_bytes("abort");
        model_reset();

`ifdef JT89_SKIP_EN
        // Redundant-write filtering relative to reset shadows.
        begin
            int s0 = skip_cnt;
            push(3'b001, 10'h00F);
            wait_idle();
            chk(skip_cnt - s0 == 1, "skip_pulse", skip_cnt - s0, 1);
        end
        push(3'b110, 10'h004);
        push(3'b110, 10'h004);
        push(3'b000, 10'h015);
        push(3'b000, 10'h01A);
        wait_idle();
        check_bytes("skip_seq");
`endif

        // Randomized commands with a flickering psg_ready.
        fork
            begin
                for (int n = 0; n < 60; n++) begin
                    logic [2:0] r;
                    logic [9:0] d;
                    r = 3'($urandom_range(0, 7));
                    d = 10'($urandom_range(0, 1023));
                    if (r[0]) d = 10'($urandom_range(12, 15));
                    else if ($urandom_range(0, 1) == 1) d[9:4] = 6'h01;
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    push(r, d);
                end
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(negedge clk);
                    psg_ready = ($urandom_range(0, 3) != 0);
                end
                psg_ready = 1'b1;
            end
        join
        wait_idle();
        check_bytes("random");
        chk(skip_cnt == exp_skips, "skip_total", skip_cnt, exp_skips);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
